// File: rtl/v_speed_repeater.sv
`default_nettype none
// ============================================================================
// Module      : v_speed_repeater
// Description : Turns a debounced "button held" level into step pulses: one
//               pulse on press, then auto-repeat pulses after an initial
//               delay, with a saturating count of repeats for soft-drop speed.
// Revision    : 1.0 - initial release
// ============================================================================
module v_speed_repeater #(
    parameter int PRESCALE     = 4096,
    parameter int DELAY_TICKS  = 24,
    parameter int REPEAT_TICKS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       level,
    output logic       pulse,
    output logic       active,
    output logic [3:0] rpt_cnt
);

    // Terminal values of the prescaler and of the two tick-count phases.
    localparam logic [15:0] C_PRESC_LAST  = 16'(PRESCALE - 1);
    localparam logic [7:0]  C_DELAY_LAST  = 8'(DELAY_TICKS - 1);
    localparam logic [7:0]  C_REPEAT_LAST = 8'(REPEAT_TICKS - 1);
    localparam logic [3:0]  C_RPT_MAX     = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_presc;
    logic [15:0] w_presc_nxt;
    logic [7:0]  r_tcnt;
    logic [7:0]  w_tcnt_nxt;
    logic [3:0]  r_rpt_cnt;
    logic [3:0]  w_rpt_cnt_nxt;
    logic        r_pulse;
    logic        w_pulse_nxt;
    logic        r_active;
    logic        w_tick;
    logic [3:0]  w_rpt_inc;

    // Prescaler terminal count; only consulted while in DELAY or REPEAT.
    assign w_tick    = (r_presc == C_PRESC_LAST);
    // Repeat counter advance, sticking at its maximum.
    assign w_rpt_inc = (r_rpt_cnt == C_RPT_MAX) ? C_RPT_MAX : r_rpt_cnt + 4'd1;

    // Next-state and next-output decode; a released button always wins over tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_presc_nxt   = r_presc;
        w_tcnt_nxt    = r_tcnt;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_pulse_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_presc_nxt   = 16'd0;
                w_tcnt_nxt    = 8'd0;
                w_rpt_cnt_nxt = 4'd0;
                if (level) begin
                    w_state_nxt = ST_DELAY;
                    w_pulse_nxt = 1'b1;
                end
            end

            ST_DELAY: begin
                if (!level) begin
                    w_state_nxt   = ST_IDLE;
                    w_presc_nxt   = 16'd0;
                    w_tcnt_nxt    = 8'd0;
                    w_rpt_cnt_nxt = 4'd0;
                end else begin
                    w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
                    if (w_tick) begin
                        if (r_tcnt == C_DELAY_LAST) begin
                            w_state_nxt   = ST_REPEAT;
                            w_pulse_nxt   = 1'b1;
                            w_tcnt_nxt    = 8'd0;
                            w_rpt_cnt_nxt = w_rpt_inc;
                        end else begin
                            w_tcnt_nxt = r_tcnt + 8'd1;
                        end
                    end
                end
            end

            ST_REPEAT: begin
                if (!level) begin
                    w_state_nxt   = ST_IDLE;
                    w_presc_nxt   = 16'd0;
                    w_tcnt_nxt    = 8'd0;
                    w_rpt_cnt_nxt = 4'd0;
                end else begin
                    w_presc_nxt = w_tick ? 16'd0 : r_presc + 16'd1;
                    if (w_tick) begin
                        if (r_tcnt == C_REPEAT_LAST) begin
                            w_pulse_nxt   = 1'b1;
                            w_tcnt_nxt    = 8'd0;
                            w_rpt_cnt_nxt = w_rpt_inc;
                        end else begin
                            w_tcnt_nxt = r_tcnt + 8'd1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_presc_nxt   = 16'd0;
                w_tcnt_nxt    = 8'd0;
                w_rpt_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_presc   <= 16'd0;
            r_tcnt    <= 8'd0;
            r_rpt_cnt <= 4'd0;
            r_pulse   <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_presc   <= w_presc_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
            r_active  <= (w_state_nxt != ST_IDLE);
        end
    end

    assign pulse   = r_pulse;
    assign active  = r_active;
    assign rpt_cnt = r_rpt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_v_speed_repeater.sv
`default_nettype none
// ============================================================================
// Module      : tb_v_speed_repeater
// Description : Self-checking bench for v_speed_repeater. Expected outputs
//               come from closed-form press/repeat timing and are queued as
//               each edge is driven, then popped and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_v_speed_repeater;

    logic       clk;
    logic       rst_n;
    logic       level_a;
    logic       level_s;
    logic       pulse_a;
    logic       active_a;
    logic [3:0] rpt_a;
    logic       pulse_s;
    logic       active_s;
    logic [3:0] rpt_s;

    typedef struct packed {
        logic       pulse;
        logic       active;
        logic [3:0] rpt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Default test-plan timing
    v_speed_repeater #(.PRESCALE(4), .DELAY_TICKS(3), .REPEAT_TICKS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .level(level_a),
        .pulse(pulse_a), .active(active_a), .rpt_cnt(rpt_a)
    );

    // Fastest timing, used for saturation
    v_speed_repeater #(.PRESCALE(1), .DELAY_TICKS(1), .REPEAT_TICKS(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .level(level_s),
        .pulse(pulse_s), .active(active_s), .rpt_cnt(rpt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Expected outputs after edge e, for a press sampled at edge 'press'
    // and level first sampled low again at edge 'rel'.
    function automatic exp_t model(input int e, input int p, input int d, input int r,
                                   input int press, input int rel);
        exp_t x;
        int   first;
        int   per;
        int   nrep;
        x = '0;
        if (e >= press && e < rel) begin
            first    = press + d * p;
            per      = r * p;
            nrep     = (e >= first) ? 1 + (e - first) / per : 0;
            x.active = 1'b1;
            x.rpt    = (nrep > 15) ? 4'd15 : 4'(nrep);
            x.pulse  = (e == press) || (e >= first && ((e - first) % per) == 0);
        end
        return x;
    endfunction

    // Drive level for edge e on the selected DUT, queue the expectation,
    // and return the DUT outputs sampled just after the edge.
    task automatic drive_edge(input bit sel, input int e, input int p, input int d,
                              input int r, input int press, input int rel,
                              output exp_t obs);
        @(negedge clk);
        if (sel) begin
            level_s = (e >= press && e < rel);
            level_a = 1'b0;
        end else begin
            level_a = (e >= press && e < rel);
            level_s = 1'b0;
        end
        sb.push_back(model(e, p, d, r, press, rel));
        @(posedge clk);
        #1;
        obs = sel ? {pulse_s, active_s, rpt_s} : {pulse_a, active_a, rpt_a};
    endtask

    task automatic test_reset();
        exp_t obs;
        exp_t ex;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            level_a = i[0];
            level_s = ~i[0];
            sb.push_back('0);
            @(posedge clk);
            #1;
            ex = sb.pop_front();
            n_checks++;
            if ({pulse_a, active_a, rpt_a} !== ex || {pulse_s, active_s, rpt_s} !== ex) begin
                n_fail++;
                $display("FAIL reset_hold i=%0d: got a=%b s=%b, want %b", i,
                         {pulse_a, active_a, rpt_a}, {pulse_s, active_s, rpt_s}, ex);
            end
        end
        @(negedge clk);
        level_a = 1'b0;
        level_s = 1'b0;
        rst_n   = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            drive_edge(1'b0, e, 4, 3, 2, 1000, 1000, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex || {pulse_s, active_s, rpt_s} !== ex) begin
                n_fail++;
                $display("FAIL reset_idle e=%0d: got a=%b s=%b, want %b", e, obs,
                         {pulse_s, active_s, rpt_s}, ex);
            end
        end
    endtask

    task automatic test_press_hold();
        exp_t obs;
        exp_t ex;
        for (int e = 1; e <= 72; e++) begin
            drive_edge(1'b0, e, 4, 3, 2, 10, 70, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL press_hold e=%0d: got p=%b a=%b r=%0d, want p=%b a=%b r=%0d",
                         e, obs.pulse, obs.active, obs.rpt, ex.pulse, ex.active, ex.rpt);
            end
        end
    endtask

    task automatic test_short_press();
        exp_t obs;
        exp_t ex;
        for (int e = 1; e <= 25; e++) begin
            drive_edge(1'b0, e, 4, 3, 2, 10, 21, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL short_press e=%0d: got p=%b a=%b r=%0d, want p=%b a=%b r=%0d",
                         e, obs.pulse, obs.active, obs.rpt, ex.pulse, ex.active, ex.rpt);
            end
        end
    endtask

    task automatic test_release_at_expiry();
        exp_t obs;
        exp_t ex;
        for (int e = 1; e <= 25; e++) begin
            drive_edge(1'b0, e, 4, 3, 2, 10, 22, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL release_expiry e=%0d: got p=%b a=%b r=%0d, want p=%b a=%b r=%0d",
                         e, obs.pulse, obs.active, obs.rpt, ex.pulse, ex.active, ex.rpt);
            end
        end
    endtask

    task automatic test_saturation();
        exp_t obs;
        exp_t ex;
        for (int e = 1; e <= 55; e++) begin
            drive_edge(1'b1, e, 1, 1, 1, 10, 50, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL saturation e=%0d: got p=%b a=%b r=%0d, want p=%b a=%b r=%0d",
                         e, obs.pulse, obs.active, obs.rpt, ex.pulse, ex.active, ex.rpt);
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t obs;
        exp_t ex;
        // Hold through the fifth repeat pulse (edge 54), leaving rpt_cnt=5
        for (int e = 1; e <= 54; e++) begin
            drive_edge(1'b0, e, 4, 3, 2, 10, 1000, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL async_pre e=%0d: got p=%b a=%b r=%0d, want p=%b a=%b r=%0d",
                         e, obs.pulse, obs.active, obs.rpt, ex.pulse, ex.active, ex.rpt);
            end
        end
        n_checks++;
        if (obs !== {1'b1, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL async_before_reset: got %b, want %b", obs, {1'b1, 1'b1, 4'd5});
        end
        // Short reset pulse between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pulse_a, active_a, rpt_a} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_immediate: got %b, want %b", {pulse_a, active_a, rpt_a}, 6'b0);
        end
        rst_n = 1'b1;
        // Level still high: fresh press on the first edge, then normal timing
        for (int e = 1; e <= 23; e++) begin
            drive_edge(1'b0, e, 4, 3, 2, 1, 21, obs);
            ex = sb.pop_front();
            n_checks++;
            if (obs !== ex) begin
                n_fail++;
                $display("FAIL async_post e=%0d: got p=%b a=%b r=%0d, want p=%b a=%b r=%0d",
                         e, obs.pulse, obs.active, obs.rpt, ex.pulse, ex.active, ex.rpt);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        level_a = 1'b0;
        level_s = 1'b0;
        test_reset();
        test_press_hold();
        test_short_press();
        test_release_at_expiry();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
